// File: rtl/game_pkg.sv
// Shared definitions for the note game's video path: screen geometry, the
// "no note" marker, palette entries and the sprite drawer's state encoding.
// No ports; imported by note_sprite_drawer and rect_scanner.
package game_pkg;

    // VGA adapter resolution (160x120, 3-bit colour).
    localparam int unsigned SCREEN_W = 160;
    localparam int unsigned SCREEN_H = 120;

    // note_y value meaning "this lane has no note this frame".
    localparam logic [7:0] NO_NOTE_Y = 8'hFF;

    // Palette entries used by the lane drawers.
    localparam logic [2:0] COLOUR_BLACK  = 3'b000;
    localparam logic [2:0] COLOUR_YELLOW = 3'b110;

    // Scan counter widths: cover NOTE_W up to 32 and NOTE_H up to 16.
    localparam int unsigned DX_W = 5;
    localparam int unsigned DY_W = 4;

    typedef enum logic [1:0] {
        StIdle,
        StErase,
        StDraw,
        StFinish
    } drawer_state_e;

    // Coordinates are 9-bit sums so a rectangle hanging off the bottom or
    // right edge is clipped rather than wrapped back onto the screen.
    function automatic logic on_screen(input logic [8:0] x, input logic [8:0] y);
        return (x <= 9'(SCREEN_W - 1)) && (y <= 9'(SCREEN_H - 1));
    endfunction

endpackage

// File: rtl/rect_scanner.sv
// Row-major scan counter over a NOTE_W x NOTE_H rectangle.
//   clk_i     : clock, rising edge
//   rst_ni    : synchronous active-low reset
//   clear_i   : restart the scan at (0,0); wins over advance_i
//   advance_i : step to the next pixel (dx inner, dy outer), wraps after last
//   dx_o/dy_o : current offset inside the rectangle
//   last_o    : current offset is the final pixel (NOTE_W-1, NOTE_H-1)
module rect_scanner
    import game_pkg::*;
#(
    parameter int unsigned NOTE_W = 16,
    parameter int unsigned NOTE_H = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            clear_i,
    input  logic            advance_i,
    output logic [DX_W-1:0] dx_o,
    output logic [DY_W-1:0] dy_o,
    output logic            last_o
);

    localparam logic [DX_W-1:0] DxLast = DX_W'(NOTE_W - 1);
    localparam logic [DY_W-1:0] DyLast = DY_W'(NOTE_H - 1);

    logic [DX_W-1:0] dx_q, dx_d;
    logic [DY_W-1:0] dy_q, dy_d;
    logic            row_end;

    assign row_end = (dx_q == DxLast);

    always_comb begin
        dx_d = dx_q;
        dy_d = dy_q;
        if (clear_i) begin
            dx_d = '0;
            dy_d = '0;
        end else if (advance_i) begin
            if (row_end) begin
                dx_d = '0;
                // Wrapping at the end lets ERASE hand over straight to DRAW.
                dy_d = (dy_q == DyLast) ? '0 : dy_q + 1'b1;
            end else begin
                dx_d = dx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            dx_q <= '0;
            dy_q <= '0;
        end else begin
            dx_q <= dx_d;
            dy_q <= dy_d;
        end
    end

    assign dx_o   = dx_q;
    assign dy_o   = dy_q;
    assign last_o = row_end && (dy_q == DyLast);

endmodule

// File: rtl/note_sprite_drawer.sv
// Per-lane note sprite drawer. On each frame tick it erases the note
// rectangle at the previous y (if one was drawn) and draws it at the new y,
// streaming one registered pixel per clock to the VGA adapter write port.
//   clk        : clock, rising edge
//   resetn     : synchronous active-low reset, abandons any frame in flight
//   start      : frame tick, only honoured while idle
//   note_y     : new note top row, 8'hFF = no note
//   vga_x/y    : pixel coordinate (y is the low 7 bits of the 9-bit sum)
//   vga_colour : pixel colour (background while erasing, note while drawing)
//   vga_plot   : write strobe, low for pixels clipped off screen
//   busy       : high from the cycle after an accepted start through done
//   done       : one-cycle pulse when the frame update is complete
module note_sprite_drawer
    import game_pkg::*;
#(
    parameter logic [7:0]  LANE_X      = 8'd0,
    parameter int unsigned NOTE_W      = 16,
    parameter int unsigned NOTE_H      = 4,
    parameter logic [2:0]  NOTE_COLOUR = COLOUR_YELLOW,
    parameter logic [2:0]  BG_COLOUR   = COLOUR_BLACK
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic [7:0] note_y,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot,
    output logic       busy,
    output logic       done
);

    drawer_state_e state_q, state_d;

    logic [7:0] new_y_q, new_y_d;
    logic [7:0] prev_y_q, prev_y_d;
    logic       prev_valid_q, prev_valid_d;

    logic [7:0] vga_x_q, vga_x_d;
    logic [6:0] vga_y_q, vga_y_d;
    logic [2:0] vga_colour_q, vga_colour_d;
    logic       vga_plot_q, vga_plot_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic            scan_clear;
    logic            scan_advance;
    logic [DX_W-1:0] scan_dx;
    logic [DY_W-1:0] scan_dy;
    logic            scan_last;

    logic [7:0] base_y;
    logic [8:0] x_sum;
    logic [8:0] y_sum;

    rect_scanner #(
        .NOTE_W (NOTE_W),
        .NOTE_H (NOTE_H)
    ) u_scanner (
        .clk_i     (clk),
        .rst_ni    (resetn),
        .clear_i   (scan_clear),
        .advance_i (scan_advance),
        .dx_o      (scan_dx),
        .dy_o      (scan_dy),
        .last_o    (scan_last)
    );

    // Pixel address for the current scan position of whichever phase is active.
    assign base_y = (state_q == StErase) ? prev_y_q : new_y_q;
    assign x_sum  = {1'b0, LANE_X} + 9'(scan_dx);
    assign y_sum  = {1'b0, base_y} + 9'(scan_dy);

    always_comb begin
        state_d      = state_q;
        new_y_d      = new_y_q;
        prev_y_d     = prev_y_q;
        prev_valid_d = prev_valid_q;
        vga_x_d      = vga_x_q;
        vga_y_d      = vga_y_q;
        vga_colour_d = vga_colour_q;
        vga_plot_d   = 1'b0;
        done_d       = 1'b0;
        // Registered, so busy trails the state by one cycle like the pixels do.
        busy_d       = (state_q != StIdle);
        scan_clear   = 1'b0;
        scan_advance = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    new_y_d    = note_y;
                    scan_clear = 1'b1;
                    if (prev_valid_q) begin
                        state_d = StErase;
                    end else if (note_y == NO_NOTE_Y) begin
                        state_d = StFinish;
                    end else begin
                        state_d = StDraw;
                    end
                end
            end

            StErase, StDraw: begin
                vga_x_d      = x_sum[7:0];
                vga_y_d      = y_sum[6:0];
                vga_colour_d = (state_q == StErase) ? BG_COLOUR : NOTE_COLOUR;
                vga_plot_d   = on_screen(x_sum, y_sum);
                scan_advance = 1'b1;
                if (scan_last) begin
                    if (state_q == StErase && new_y_q != NO_NOTE_Y) begin
                        state_d = StDraw;
                    end else begin
                        state_d = StFinish;
                    end
                end
            end

            StFinish: begin
                done_d       = 1'b1;
                prev_y_d     = new_y_q;
                prev_valid_d = (new_y_q != NO_NOTE_Y);
                state_d      = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= StIdle;
            new_y_q      <= '0;
            prev_y_q     <= '0;
            prev_valid_q <= 1'b0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
            vga_plot_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            new_y_q      <= new_y_d;
            prev_y_q     <= prev_y_d;
            prev_valid_q <= prev_valid_d;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_colour_q <= vga_colour_d;
            vga_plot_q   <= vga_plot_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign vga_x      = vga_x_q;
    assign vga_y      = vga_y_q;
    assign vga_colour = vga_colour_q;
    assign vga_plot   = vga_plot_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_note_sprite_drawer.sv
module tb_note_sprite_drawer;

    localparam int LX = 20;
    localparam int W  = 16;
    localparam int H  = 4;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0;
    logic [7:0] note_y = 8'd0;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;
    logic       busy;
    logic       done;

    always #5 clk = ~clk;

    note_sprite_drawer #(
        .LANE_X      (8'd20),
        .NOTE_W      (16),
        .NOTE_H      (4),
        .NOTE_COLOUR (3'b110),
        .BG_COLOUR   (3'b000)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .note_y     (note_y),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot),
        .busy       (busy),
        .done       (done)
    );

    typedef struct {
        bit is_done;
        int x;
        int y;
        int colour;
        bit plot;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  passed = 0;

    // Reference model state: what is currently on screen for this lane.
    bit  m_prev_valid = 1'b0;
    int  m_prev_y = 0;

    function automatic void chk(input bit ok, input string name, input string detail);
        checks++;
        if (ok) passed++;
        else $display("FAIL %s: %s", name, detail);
    endfunction

    function automatic void push_rect(input int base, input int colour);
        for (int dy = 0; dy < H; dy++) begin
            for (int dx = 0; dx < W; dx++) begin
                ev_t e;
                e.is_done = 1'b0;
                e.x       = LX + dx;
                e.y       = base + dy;
                e.colour  = colour;
                e.plot    = (e.x <= 159) && (e.y <= 119);
                exp_q.push_back(e);
            end
        end
    endfunction

    // Queues the whole expected frame and returns its pixel count.
    function automatic int model_frame(input int ny);
        ev_t d;
        int  n = 0;
        if (m_prev_valid) begin
            push_rect(m_prev_y, 0);
            n += W * H;
        end
        if (ny != 255) begin
            push_rect(ny, 6);
            n += W * H;
        end
        d.is_done = 1'b1;
        d.x = 0; d.y = 0; d.colour = 0; d.plot = 1'b0;
        exp_q.push_back(d);
        m_prev_valid = (ny != 255);
        m_prev_y     = ny;
        return n;
    endfunction

    // Monitor: a pixel is on the port in every busy cycle except the done cycle.
    always @(negedge clk) begin
        if (busy && !done) begin
            if (exp_q.size() == 0) begin
                chk(1'b0, "unexpected_pixel", $sformatf("got x=%0d y=%0d, required none",
                    vga_x, vga_y));
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                chk(!e.is_done && vga_x == 8'(e.x) && vga_y == 7'(e.y)
                    && vga_colour == 3'(e.colour) && vga_plot == e.plot, "pixel",
                    $sformatf("got done=0 x=%0d y=%0d c=%0d p=%0d, required done=%0d x=%0d y=%0d c=%0d p=%0d",
                    vga_x, vga_y, vga_colour, vga_plot, e.is_done, 8'(e.x), 7'(e.y),
                    e.colour, e.plot));
            end
        end else if (done) begin
            if (exp_q.size() == 0) begin
                chk(1'b0, "unexpected_done", "got done=1, required no event");
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                chk(e.is_done && vga_plot == 1'b0, "done_event",
                    $sformatf("got done=1 plot=%0d, required done=%0d plot=0", vga_plot,
                    e.is_done));
            end
        end
    end

    task automatic run_frame(input int ny, input bit mid);
        int exp_n;
        int cyc;
        bit got;
        exp_n = model_frame(ny);
        @(negedge clk);
        start  = 1'b1;
        note_y = 8'(ny);
        @(negedge clk);
        start = 1'b0;
        chk(busy == 1'b0, "busy_cycle0", $sformatf("got %0d, required 0", busy));
        cyc = 0;
        got = 1'b0;
        while (cyc < 400 && !got) begin
            @(negedge clk);
            cyc++;
            if (mid && cyc == 10) begin
                start  = 1'b1;
                note_y = 8'($urandom_range(0, 255));
            end else begin
                start = 1'b0;
            end
            if (done) got = 1'b1;
            else if (!busy) begin
                chk(1'b0, "busy_drop", $sformatf("got busy=0 at cycle %0d, required 1", cyc));
                break;
            end
        end
        start = 1'b0;
        chk(got && cyc == exp_n + 1, "done_latency",
            $sformatf("got done=%0d at cycle %0d, required cycle %0d", got, cyc, exp_n + 1));
        if (!got) $fatal(1, "FAIL timeout: no done within 400 cycles for note_y=%0d", ny);
        @(negedge clk);
        chk(busy == 1'b0 && done == 1'b0, "after_done",
            $sformatf("got busy=%0d done=%0d, required 0 0", busy, done));
    endtask

    initial begin
        int ny;
        repeat (3) @(negedge clk);
        chk(vga_x == 0 && vga_y == 0 && vga_colour == 0, "reset_pixel",
            $sformatf("got x=%0d y=%0d c=%0d, required 0 0 0", vga_x, vga_y, vga_colour));
        chk(vga_plot == 0 && busy == 0 && done == 0, "reset_ctrl",
            $sformatf("got plot=%0d busy=%0d done=%0d, required 0 0 0", vga_plot, busy, done));
        resetn = 1'b1;

        // Directed frames from the test plan.
        run_frame(10, 1'b0);
        run_frame(12, 1'b0);
        run_frame(118, 1'b0);
        run_frame(50, 1'b0);
        run_frame(255, 1'b0);
        run_frame(5, 1'b0);
        run_frame(5, 1'b0);
        run_frame(200, 1'b1);
        run_frame(255, 1'b0);
        run_frame(255, 1'b0);
        run_frame(60, 1'b1);

        // Reset in the middle of an erase.
        run_frame(30, 1'b0);
        void'(model_frame(40));
        @(negedge clk);
        start  = 1'b1;
        note_y = 8'd40;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        chk(vga_plot == 1'b0 && busy == 1'b0 && done == 1'b0, "reset_mid_erase",
            $sformatf("got plot=%0d busy=%0d done=%0d, required 0 0 0", vga_plot, busy, done));
        exp_q.delete();
        m_prev_valid = 1'b0;
        resetn = 1'b1;
        run_frame(7, 1'b0);

        // Randomised frames.
        for (int i = 0; i < 14; i++) begin
            case ($urandom_range(0, 3))
                0:       ny = 255;
                1:       ny = $urandom_range(0, 115);
                2:       ny = $urandom_range(114, 125);
                default: ny = $urandom_range(0, 254);
            endcase
            run_frame(ny, 1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        chk(exp_q.size() == 0, "queue_drained",
            $sformatf("got %0d events left, required 0", exp_q.size()));
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/note_sprite_drawer.md
Name: note_sprite_drawer

Overview:
Downstream consumer of a lane's double-buffered note position (8-bit y from the per-lane double-buffering stage). Once per frame tick it erases the note rectangle at the previous y and draws it at the new y. It emits one pixel per clock to the 160x120 VGA adapter write port (x, y, colour, plot). One instance per lane; lanes are arbitrated externally using busy/done.

Parameters:
LANE_X, 8'd0, left x coordinate of this lane's note rectangle
NOTE_W, 16, rectangle width in pixels (1..32)
NOTE_H, 4, rectangle height in pixels (1..16)
NOTE_COLOUR, 3'b110, colour for drawn pixels
BG_COLOUR, 3'b000, colour for erased pixels

Ports:
clk  in  1  system clock; all logic on rising edge
resetn  in  1  synchronous active-low reset
start  in  1  frame-tick pulse; sampled only in IDLE
note_y  in  8  new note top row from double-buffer stage; 8'hFF = no note
vga_x  out  8  pixel x
vga_y  out  7  pixel y
vga_colour  out  3  pixel colour
vga_plot  out  1  write strobe for current pixel
busy  out  1  high from cycle after accepted start until done
done  out  1  one-cycle pulse when frame update is complete

Behaviour:
- Interface: one clock, clk. Reset resetn is synchronous and active-low.
- Reset state: state=IDLE, vga_x=0, vga_y=0, vga_colour=0, vga_plot=0, busy=0, done=0, prev_valid=0, prev_y=0, counters=0.
- The reset condition has priority over all other activity. Reset mid-operation abandons the frame at once with no further plots. Because prev_valid is cleared, the next frame skips erase.
- States: IDLE, ERASE, DRAW, FINISH.
- IDLE: on start=1, latch new_y<=note_y and go to ERASE if prev_valid, otherwise to DRAW. start in any other state is ignored; it is not queued.
- ERASE/DRAW: scan the rectangle row-major, dx 0..NOTE_W-1 inner, dy 0..NOTE_H-1 outer, one pixel per cycle.
  - Outputs are registered: vga_x=LANE_X+dx, vga_y=base_y+dy (low 7 bits), colour=BG_COLOUR in ERASE and NOTE_COLOUR in DRAW.
  - base_y is prev_y in ERASE and new_y in DRAW.
  - vga_plot=1 only when base_y+dy <= 119 and LANE_X+dx <= 159. Sums are computed at 9 bits, with no wrap. Clipped pixels still consume their cycle, with plot=0.
- ERASE to DRAW after the last pixel (dx=NOTE_W-1, dy=NOTE_H-1). If new_y==8'hFF, go from ERASE straight to FINISH and skip DRAW.
- DRAW with new_y==8'hFF is never entered. When prev_valid=0 and new_y==8'hFF, IDLE goes directly to FINISH.
- FINISH (one cycle): vga_plot=0, done=1.
  - prev_y<=new_y.
  - prev_valid<=(new_y!=8'hFF).
  - Then return to IDLE, with done low the next cycle.
- Latency, with start sampled at edge k:
  - First pixel is valid in the cycle after edge k+1.
  - Full erase+draw takes 2*NOTE_W*NOTE_H pixel cycles.
  - done occurs at pixel cycles + 1. Default is 128 pixel cycles, done in the 129th cycle after acceptance.
- busy=1 in ERASE, DRAW and FINISH; 0 in IDLE.
- If note_y equals prev_y, the full erase+draw still happens; no optimisation.

Decomposition:
- Shared package game_pkg:
  - SCREEN_W=160, SCREEN_H=120
  - NO_NOTE_Y=8'hFF
  - colour constants
  - state enum for the drawer
- One natural sub-module, rect_scanner. Inputs are clear/advance; outputs are dx, dy and a last flag. It is parameterised by NOTE_W and NOTE_H and reused for both phases.

Test Plan:
- Reset then start with note_y=10, LANE_X=20, defaults -> no erase; 64 plots with x 20..35, y 10..13, colour 110; done at cycle 65; busy high cycles 1..65.
- Second start with note_y=12 -> 64 plots at y 10..13 in colour 000, then 64 plots at y 12..15 in colour 110; done at cycle 129.
- note_y=118 -> rows 118,119 plotted; rows 120,121 present with plot=0; 128 cycles total; prev_y=118.
- Previous y=50, start with note_y=8'hFF -> 64 erase plots at y 50..53, no draw, done at cycle 65. The next start with note_y=5 -> no erase, draw only.
- start pulsed mid-DRAW -> ignored, the frame completes unchanged. resetn=0 during ERASE -> the next cycle has plot=0 and busy=0, and the following start skips erase.
